mips_run_checker: RTL and testbench

Synthesizable end-of-run detector and result scorer for the pipelined MIPS core. It watches the instruction bus for a run of consecutive NOPs, bounded by a watchdog cycle limit, to decide when a program has finished. It then scans a window of data memory, compares each word against an expected-value ROM, and keeps saturating pass counts per instruction category. It sits beside `instmem`/`datamem` so the pass/fail tally runs on hardware rather than only in simulation.

---
 rtl/mips_chk_pkg.sv | 18 +
 rtl/mips_run_detect.sv | 41 ++++
 rtl/mips_run_checker.sv | 126 ++++++++++++
 tb/tb_mips_run_checker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_chk_pkg.sv
// Shared types and category indices for the MIPS end-of-run checker.
package mips_chk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, SCAN, DONE} state_t;

  localparam int CAT_LDST = 0;
  localparam int CAT_ADD  = 1;
  localparam int CAT_ADDI = 2;
  localparam int CAT_SUB  = 3;
  localparam int CAT_SLT  = 4;
  localparam int CAT_SLTI = 5;
  localparam int CAT_BEQ  = 6;
  localparam int CAT_BNE  = 7;
  localparam int CAT_JUMP = 8;
  localparam int CAT_JAL  = 9;
  localparam int CAT_JR   = 10;

endpackage

// File: rtl/mips_run_detect.sv
// NOP-streak and watchdog counters; flags the cycle in which a run ends.
module mips_run_detect #(
  parameter int NOP_TIMEOUT = 9,
  parameter int WATCHDOG    = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        active,
  input  logic [31:0] inst,
  output logic        end_run,
  output logic        wd_hit
);

  localparam int NOP_W = $clog2(NOP_TIMEOUT + 1);
  localparam int CYC_W = $clog2(WATCHDOG + 1);
  localparam logic [NOP_W-1:0] NOP_LAST = NOP_W'(NOP_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WATCHDOG - 1);

  logic [NOP_W-1:0] nop_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic             nop_hit;
  logic             cyc_hit;

  // Both limits include the current sample, so compare against limit-1.
  assign nop_hit = (inst == '0) && (nop_cnt == NOP_LAST);
  assign cyc_hit = (cyc_cnt == CYC_LAST);
  assign end_run = active && (nop_hit || cyc_hit);
  assign wd_hit  = active && cyc_hit && !nop_hit;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      nop_cnt <= '0;
      cyc_cnt <= '0;
    end else if (active) begin
      cyc_cnt <= cyc_cnt + 1'b1;
      nop_cnt <= (inst == '0) ? nop_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/mips_run_checker.sv
// End-of-run detector plus data-memory scan that scores words against an
// expected-value ROM into saturating per-category pass counters.
module mips_run_checker
  import mips_chk_pkg::*;
#(
  parameter int          NOP_TIMEOUT = 9,
  parameter int          WATCHDOG    = 500,
  parameter int          NUM_WORDS   = 75,
  parameter int          NUM_CAT     = 11,
  parameter int          CNT_W       = 8,
  parameter logic [31:0] ADJ_OFFSET  = 32'h0000_3000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [31:0]                inst,
  output logic                       mem_rd_en,
  output logic [31:0]                mem_addr,
  input  logic [31:0]                mem_rd_data,
  input  logic [31:0]                exp_data,
  input  logic [$clog2(NUM_CAT)-1:0] exp_cat,
  input  logic                       exp_valid,
  input  logic                       exp_adj,
  output logic                       busy,
  output logic                       done,
  output logic                       timed_out,
  output logic [NUM_CAT*CNT_W-1:0]   pass_cnt,
  output logic [15:0]                total_pass
);

  localparam int IDX_W = $clog2(NUM_WORDS + 1);
  localparam logic [IDX_W-1:0] IDX_DRAIN = IDX_W'(NUM_WORDS);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             clear;
  logic             end_run;
  logic             wd_hit;
  logic             vld_p0, vld_p1;
  logic             score;
  logic [CNT_W-1:0] cnt_q [NUM_CAT];

  function automatic logic [31:0] exp_target(input logic [31:0] d, input logic adj);
    return adj ? d - ADJ_OFFSET : d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [15:0] sat_total(input logic [15:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  mips_run_detect #(
    .NOP_TIMEOUT(NOP_TIMEOUT),
    .WATCHDOG   (WATCHDOG)
  ) u_detect (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .active (state_q == RUN),
    .inst   (inst),
    .end_run(end_run),
    .wd_hit (wd_hit)
  );

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = RUN;
        clear   = 1'b1;
      end
      RUN:     if (end_run) state_d = SCAN;
      SCAN:    if (idx_q == IDX_DRAIN) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: read issue, one word index per SCAN cycle until the drain slot.
  assign vld_p0    = (state_q == SCAN) && (idx_q != IDX_DRAIN);
  assign mem_rd_en = vld_p0;
  assign mem_addr  = vld_p0 ? 32'({idx_q, 2'b00}) : '0;
  assign busy      = (state_q == RUN) || (state_q == SCAN);
  assign done      = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= (state_q == SCAN) ? idx_q + 1'b1 : '0;
      vld_p1  <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) timed_out <= 1'b0;
    else if (wd_hit)  timed_out <= 1'b1;
  end

  // Stage p1: read data and ROM entry are back; score straight into the counters.
  assign score = vld_p1 && exp_valid && (int'(exp_cat) < NUM_CAT) &&
                 (mem_rd_data == exp_target(exp_data, exp_adj));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int c = 0; c < NUM_CAT; c++) cnt_q[c] <= '0;
      total_pass <= '0;
    end else if (score) begin
      total_pass <= sat_total(total_pass);
      for (int c = 0; c < NUM_CAT; c++)
        if (int'(exp_cat) == c) cnt_q[c] <= sat_cnt(cnt_q[c]);
    end
  end

  always_comb begin
    pass_cnt = '0;
    for (int c = 0; c < NUM_CAT; c++) pass_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
  end

endmodule

// File: tb/tb_mips_run_checker.sv
// Directed bench: scoreboard of expected run outcomes checked by a monitor on done.
module tb_mips_run_checker;

  localparam int NW = 75;
  localparam int NC = 11;
  localparam logic [31:0] NZ = 32'h2008_0001;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] inst;
  logic        mem_rd_en, busy, done, timed_out;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data = '0, exp_data = '0;
  logic [3:0]  exp_cat = '0;
  logic        exp_valid = 1'b0, exp_adj = 1'b0;
  logic [NC*8-1:0] pass_cnt;
  logic [15:0] total_pass;

  logic        mem_rd_en_s, busy_s, done_s, timed_out_s;
  logic [31:0] mem_addr_s;
  logic [NC*2-1:0] pass_cnt_s;
  logic [15:0] total_pass_s;

  mips_run_checker dut (
    .clk(clk), .rst(rst), .start(start), .inst(inst),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .exp_data(exp_data), .exp_cat(exp_cat), .exp_valid(exp_valid), .exp_adj(exp_adj),
    .busy(busy), .done(done), .timed_out(timed_out),
    .pass_cnt(pass_cnt), .total_pass(total_pass)
  );

  mips_run_checker #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .inst(inst),
    .mem_rd_en(mem_rd_en_s), .mem_addr(mem_addr_s), .mem_rd_data(mem_rd_data),
    .exp_data(exp_data), .exp_cat(exp_cat), .exp_valid(exp_valid), .exp_adj(exp_adj),
    .busy(busy_s), .done(done_s), .timed_out(timed_out_s),
    .pass_cnt(pass_cnt_s), .total_pass(total_pass_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]     run;
    logic            to;
    logic [NC*8-1:0] cnt;
    logic [15:0]     total;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [31:0] mem_arr [NW];
  logic [31:0] rom_arr [NW];
  logic [3:0]  cat_arr [NW];
  logic        vld_arr [NW];
  logic        adj_arr [NW];

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input int run, input logic to, input logic scored);
    exp_t e;
    e = '0;
    e.run = 16'(run);
    e.to  = to;
    if (scored) begin
      e.cnt[0*8 +: 8]  = 8'd3;
      e.cnt[1*8 +: 8]  = 8'd5;
      e.cnt[2*8 +: 8]  = 8'd1;
      e.cnt[3*8 +: 8]  = 8'd1;
      e.cnt[9*8 +: 8]  = 8'd1;
      e.cnt[10*8 +: 8] = 8'd1;
      e.total = 16'd12;
    end
    return e;
  endfunction

  task automatic load_rom(input logic scored);
    for (int i = 0; i < NW; i++) begin
      mem_arr[i] = 32'hA500_0000 + 32'(i);
      rom_arr[i] = mem_arr[i];
      cat_arr[i] = 4'd0;
      vld_arr[i] = 1'b0;
      adj_arr[i] = 1'b0;
    end
    if (scored) begin
      vld_arr[0] = 1'b1; cat_arr[0] = 4'd2;
      foreach (vld_arr[i]) if (i == 3 || i == 4 || i == 6) vld_arr[i] = 1'b1;
      vld_arr[5] = 1'b1; rom_arr[5] = mem_arr[5] + 32'd1;
      vld_arr[20] = 1'b1; cat_arr[20] = 4'd12;
      vld_arr[34] = 1'b1; cat_arr[34] = 4'd9; adj_arr[34] = 1'b1;
      mem_arr[34] = 32'h0000_0040; rom_arr[34] = 32'h0000_3040;
      vld_arr[35] = 1'b1; cat_arr[35] = 4'd9; adj_arr[35] = 1'b1;
      vld_arr[36] = 1'b1; cat_arr[36] = 4'd9;
      mem_arr[36] = 32'h0000_0040; rom_arr[36] = 32'h0000_3040;
      vld_arr[40] = 1'b1; cat_arr[40] = 4'd3;
      for (int i = 50; i < 55; i++) begin vld_arr[i] = 1'b1; cat_arr[i] = 4'd1; end
      vld_arr[74] = 1'b1; cat_arr[74] = 4'd10;
    end
  endtask

  // Memory / ROM responder; when idle it presents a matching scored entry as bait.
  always @(posedge clk) begin
    int k;
    logic [31:0] r;
    k = int'(mem_addr[8:2]);
    if (mem_rd_en && k < NW) begin
      mem_rd_data <= mem_arr[k];
      exp_data    <= rom_arr[k];
      exp_cat     <= cat_arr[k];
      exp_valid   <= vld_arr[k];
      exp_adj     <= adj_arr[k];
    end else begin
      r = $urandom;
      mem_rd_data <= r;
      exp_data    <= r;
      exp_cat     <= 4'd0;
      exp_valid   <= 1'b1;
      exp_adj     <= 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start && !busy) start_cyc <= cyc + 1;
  end

  int   seen_start = 0;
  int   scan_cnt = 0, addr_err = 0, sat_err = 0;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    int   ev, es;
    if (start_cyc != seen_start) begin
      seen_start = start_cyc;
      scan_cnt = 0; addr_err = 0; sat_err = 0;
    end
    if (mem_rd_en_s != mem_rd_en || mem_addr_s != mem_addr || busy_s != busy || done_s != done)
      sat_err++;
    if (mem_rd_en) begin
      if (scan_cnt == 0 && q.size() > 0) check("scan_entry_cycle", cyc - start_cyc, q[0].run);
      if (mem_addr != 32'(scan_cnt * 4)) addr_err++;
      scan_cnt++;
    end
    if (done && !done_prev) begin
      if (q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        check("done_latency", cyc - start_cyc, int'(e.run) + NW + 1);
        check("timed_out", timed_out, e.to);
        check("scan_words", scan_cnt, NW);
        check("addr_seq_errors", addr_err, 0);
        for (int c = 0; c < NC; c++) begin
          ev = int'(e.cnt[c*8 +: 8]);
          es = (ev > 3) ? 3 : ev;
          check($sformatf("pass_cnt[%0d]", c), pass_cnt[c*8 +: 8], ev);
          check($sformatf("sat_pass_cnt[%0d]", c), pass_cnt_s[c*2 +: 2], es);
        end
        check("total_pass", total_pass, e.total);
        check("sat_total_pass", total_pass_s, e.total);
        check("sat_timed_out", timed_out_s, e.to);
        check("sat_ctrl_errors", sat_err, 0);
      end
    end
    done_prev = done;
  end

  task automatic drive(input int n, input logic [31:0] v);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      inst  = v;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
    @(negedge clk);
    inst = '0;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; inst = '0;
    load_rom(1'b0);
    repeat (2) @(negedge clk);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timed_out", timed_out, 0);
    check("rst_pass_cnt_zero", pass_cnt == '0, 1);
    check("rst_total", total_pass, 0);
    rst = 1'b0;

    // NOP exit after five real instructions
    q.push_back(mk_exp(14, 1'b0, 1'b0));
    pulse_start(); drive(5, NZ); drive(9, '0);
    wait_done(200);

    // broken streak
    q.push_back(mk_exp(18, 1'b0, 1'b0));
    pulse_start(); drive(8, '0); drive(1, NZ); drive(9, '0);
    wait_done(200);

    // watchdog
    q.push_back(mk_exp(500, 1'b1, 1'b0));
    pulse_start(); drive(500, NZ);
    wait_done(200);

    // watchdog and NOP limit in the same cycle
    q.push_back(mk_exp(500, 1'b0, 1'b0));
    pulse_start(); drive(491, NZ); drive(9, '0);
    wait_done(200);

    // scoring
    load_rom(1'b1);
    q.push_back(mk_exp(9, 1'b0, 1'b1));
    pulse_start(); drive(9, '0);
    wait_done(200);

    // reset while index 40 is being issued
    pulse_start(); drive(9, '0);
    n = 0;
    while (!(mem_rd_en && mem_addr == 32'd160) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_index_40", mem_addr, 160);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midscan_rst_busy", busy, 0);
    check("midscan_rst_done", done, 0);
    check("midscan_rst_mem_rd_en", mem_rd_en, 0);
    check("midscan_rst_pass_cnt_zero", pass_cnt == '0, 1);
    @(negedge clk);
    check("post_rst_sub_cnt", pass_cnt[3*8 +: 8], 0);
    check("post_rst_total", total_pass, 0);

    q.push_back(mk_exp(9, 1'b0, 1'b1));
    pulse_start(); drive(9, '0);
    wait_done(200);

    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
